// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MEM-stage data-memory bus: data width, fault codes
// and responder state encoding.
package mem_bus_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_RANGE    = 2'b01;
   localparam logic [1:0] FLT_CONFLICT = 2'b10;
   localparam logic [1:0] FLT_BUSY     = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data RAM: asynchronous read port, one synchronous write port.
module dmem_array
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  Clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the array has no reset; the responder's clear sequence zeroes it one word per cycle.
   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// RAM-side responder for the MEM-stage data bus: post-reset clear, zero-latency reads,
// strobed writes, sticky fault capture and saturating access counters.
module dmem_responder
   import mem_bus_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 10,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       AddrIn,
   inout  wire  [DATA_W-1:0] Data,
   input  logic              ReadRAM,
   input  logic              WriteRAM,
   input  logic              FaultClr,
   output logic              Busy,
   output logic              Fault,
   output logic [1:0]        FaultCode,
   output logic [31:0]       FaultAddr,
   output logic [15:0]       ReadCount,
   output logic [15:0]       WriteCount
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_ptr;
   logic [31:0]             offset;
   logic [29:0]             word_idx;
   logic                    in_range;
   logic                    rd_low, wr_low;
   logic                    legal_rd, legal_wr;
   logic [1:0]              fault_now;
   logic                    arr_we;
   logic [ADDR_WIDTH-1:0]   arr_waddr;
   logic [DATA_W-1:0]       arr_wdata, arr_rdata;

   // Byte address to word index; the low two address bits are don't-care.
   assign offset   = AddrIn - BASE_ADDR;
   assign word_idx = offset[31:2];
   assign in_range = (AddrIn >= BASE_ADDR) && ((word_idx >> ADDR_WIDTH) == '0);

   assign rd_low   = ~ReadRAM;
   assign wr_low   = ~WriteRAM;
   assign Busy     = (state == ST_CLEAR);
   assign legal_rd = !Busy && rd_low && !wr_low && in_range;
   assign legal_wr = !Busy && wr_low && !rd_low && in_range;

   // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      fault_now = FLT_NONE;
      if (rd_low || wr_low) begin
         if (Busy)                fault_now = FLT_BUSY;
         else if (rd_low && wr_low) fault_now = FLT_CONFLICT;
         else if (!in_range)      fault_now = FLT_RANGE;
      end
   end

   // The single write port serves the clear sweep while busy and bus stores afterwards.
   assign arr_we    = !Reset && (Busy || legal_wr);
   assign arr_waddr = Busy ? clr_ptr : word_idx[ADDR_WIDTH-1:0];
   assign arr_wdata = Busy ? '0 : Data;

   dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .Clk   (Clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .raddr (word_idx[ADDR_WIDTH-1:0]),
      .rdata (arr_rdata)
   );

   // legal_rd already excludes WriteRAM low, so the bus is never fought over during a store.
   assign Data = legal_rd ? arr_rdata : 'z;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_ptr    <= '0;
         Fault      <= 1'b0;
         FaultCode  <= FLT_NONE;
         FaultAddr  <= '0;
         ReadCount  <= '0;
         WriteCount <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == '1) state <= ST_READY;
            end
            default: state <= ST_READY;
         endcase

         if (legal_rd && ReadCount != 16'hFFFF)  ReadCount  <= ReadCount + 16'd1;
         if (legal_wr && WriteCount != 16'hFFFF) WriteCount <= WriteCount + 16'd1;

         // A clear on the same edge as a new fault wins; only the first fault is kept.
         if (FaultClr) begin
            Fault     <= 1'b0;
            FaultCode <= FLT_NONE;
            FaultAddr <= '0;
         end else if (fault_now != FLT_NONE && !Fault) begin
            Fault     <= 1'b1;
            FaultCode <= fault_now;
            FaultAddr <= AddrIn;
         end
      end
   end

endmodule
